// File: rtl/instr_loader_if.sv
// Purpose: byte-stream load request and instruction-memory write bus for the loader.
// Signals:
//   load_start/load_len       : load request and word count (from host)
//   byte_in/byte_valid/ready  : program byte stream handshake
//   mem_we/mem_addr/mem_wdata : instruction memory write port (from loader)
//   busy/done_ld              : load status, done_ld starts the processor
// Modports: master = host/stream side, slave = loader side.
interface instr_loader_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done_ld;

    modport master (
        output load_start, load_len, byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata, busy, done_ld
    );

    modport slave (
        input  load_start, load_len, byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata, busy, done_ld
    );
endinterface

// File: rtl/instr_loader.sv
// Purpose: writer side of the instruction memory. Packs a valid/ready byte
// stream into little-endian 32-bit words and writes them at byte addresses
// 0, 4, 8, ...; pulses done_ld when the requested word count is written.
// Ports:
//   CLK   : clock, all state changes on posedge
//   RST_N : synchronous active-low reset
//   bus   : instr_loader_if.slave (load request, byte stream, memory write, status)
module instr_loader #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic           CLK,
    input  logic           RST_N,
    instr_loader_if.slave  bus
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         word_q, word_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                byte_ready_q, byte_ready_d;
    logic                mem_we_q, mem_we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    len_d      = (bus.load_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.load_len;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    state_d    = (len_d == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (bus.byte_valid && byte_ready_q) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_in;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Load the write port now so it is valid during WRITE
                        state_d     = WRITE;
                        mem_addr_d  = 32'({word_idx_q, 2'b00});
                        mem_wdata_d = word_d;
                    end
                end
            end
            WRITE: begin
                if (LEN_W'(word_idx_q) == len_q - LEN_W'(1)) begin
                    state_d = DONE;
                end else begin
                    word_idx_d = word_idx_q + ADDR_W'(1);
                    byte_cnt_d = '0;
                    state_d    = RECV;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs follow the state being entered so they register in step with it
        byte_ready_d = (state_d == RECV);
        mem_we_d     = (state_d == WRITE);
        busy_d       = (state_d == RECV) || (state_d == WRITE);
        done_d       = (state_d == DONE);
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.busy       = busy_q;
    assign bus.done_ld    = done_q;

endmodule

// File: tb/tb_instr_loader.sv
// Purpose: self-checking bench for instr_loader. A queue of expected memory
// writes is built from the program bytes; a negedge monitor checks every
// write and done pulse against it. Directed literal checks pin the model.
module tb_instr_loader;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = 5;

    logic CLK = 1'b0;
    logic RST_N;

    always #5 CLK = ~CLK;

    instr_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [7:0]  prog[$];
    int          done_pending = 0;
    int          cur_len = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic        prev_we = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitor: every write and done pulse must match the expected sequence
    always @(negedge CLK) begin
        if (bus.mem_we) begin
            wr_cnt++;
            last_addr = bus.mem_addr;
            last_data = bus.mem_wdata;
            if (exp_addr_q.size() == 0) begin
                flag("unexpected_write");
            end else begin
                chk("wr_addr", bus.mem_addr, exp_addr_q.pop_front());
                chk("wr_data", bus.mem_wdata, exp_data_q.pop_front());
            end
        end
        if (bus.done_ld) begin
            done_cnt++;
            chk("done_busy_low", 32'(bus.busy), 32'd0);
            if (done_pending == 0) begin
                flag("unexpected_done");
            end else begin
                done_pending--;
                chk("done_writes_left", 32'(exp_addr_q.size()), 32'd0);
                if (cur_len > 0) chk("done_after_we", 32'(prev_we), 32'd1);
            end
        end
        if (bus.byte_ready && !bus.busy) flag("ready_while_idle");
        prev_we = bus.mem_we;
    end

    // Queue expected writes for a load of len words, then issue the request
    task automatic start_load(input int len);
        int n;
        n = (len > int'(DEPTH)) ? int'(DEPTH) : len;
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(32'(4 * i));
            exp_data_q.push_back({prog[4*i+3], prog[4*i+2], prog[4*i+1], prog[4*i]});
        end
        cur_len = n;
        done_pending++;
        @(negedge CLK);
        bus.load_start = 1'b1;
        bus.load_len   = 6'(len);
        @(negedge CLK);
        bus.load_start = 1'b0;
    endtask

    // Offer prog[first .. first+count-1]; a byte advances only when accepted
    task automatic feed(input int first, input int count, input bit gaps);
        int k;
        int cyc;
        bit fire;
        k = first;
        cyc = 0;
        while (k < first + count && cyc < 2000) begin
            bus.byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.byte_in    = prog[k];
            fire = bus.byte_valid && bus.byte_ready;
            @(negedge CLK);
            cyc++;
            if (fire) k++;
        end
        bus.byte_valid = 1'b0;
        if (k < first + count) flag("feed_timeout");
    endtask

    task automatic wait_done(input int snap);
        for (int i = 0; i < 20 && done_cnt == snap; i++) begin
            @(negedge CLK);
            #1;
        end
        chk("done_seen", 32'(done_cnt - snap), 32'd1);
    endtask

    task automatic do_reset(input int edges);
        @(negedge CLK);
        RST_N = 1'b0;
        repeat (edges) @(negedge CLK);
        RST_N = 1'b1;
        exp_addr_q.delete();
        exp_data_q.delete();
        done_pending = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int w;

        // Reset with load_start and byte_valid asserted: reset wins, nothing accepted
        RST_N          = 1'b0;
        bus.load_start = 1'b1;
        bus.load_len   = 6'd1;
        bus.byte_in    = 8'h55;
        bus.byte_valid = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done_ld), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        @(negedge CLK);
        chk("rst_ready_held", 32'(bus.byte_ready), 32'd0);
        bus.load_start = 1'b0;
        bus.byte_valid = 1'b0;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_idle", 32'(bus.busy), 32'd0);

        // Single word, valid held high
        prog = '{8'h13, 8'h00, 8'h00, 8'h00};
        s = done_cnt; w = wr_cnt;
        start_load(1);
        feed(0, 4, 1'b0);
        wait_done(s);
        chk("t2_writes", 32'(wr_cnt - w), 32'd1);
        chk("t2_addr", last_addr, 32'h0);
        chk("t2_data", last_data, 32'h0000_0013);
        chk("t2_busy_low", 32'(bus.busy), 32'd0);

        // Three words with a load_start pulse mid-load that must be ignored
        prog = '{8'h93, 8'h00, 8'h50, 8'h00,
                 8'h13, 8'h01, 8'hA0, 8'h00,
                 8'hB3, 8'h81, 8'h20, 8'h00};
        s = done_cnt; w = wr_cnt;
        start_load(3);
        feed(0, 6, 1'b0);
        bus.load_start = 1'b1;
        bus.load_len   = 6'd1;
        @(negedge CLK);
        bus.load_start = 1'b0;
        feed(6, 6, 1'b0);
        wait_done(s);
        chk("t3_writes", 32'(wr_cnt - w), 32'd3);
        chk("t3_addr", last_addr, 32'h8);
        chk("t3_data", last_data, 32'h0020_81B3);

        // Two words with random valid gaps
        prog = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
        s = done_cnt; w = wr_cnt;
        start_load(2);
        feed(0, 8, 1'b1);
        wait_done(s);
        chk("t4_writes", 32'(wr_cnt - w), 32'd2);
        chk("t4_data", last_data, 32'h1234_5678);

        // Over-length request clamps to DEPTH words
        prog.delete();
        for (int i = 0; i < 128; i++) prog.push_back(8'(i * 37 + 1));
        s = done_cnt; w = wr_cnt;
        start_load(40);
        feed(0, 128, 1'b0);
        wait_done(s);
        chk("t5_writes", 32'(wr_cnt - w), 32'd32);
        chk("t5_last_addr", last_addr, 32'h7C);
        chk("t5_last_data", last_data, 32'h5C37_12ED);

        // Zero-length request: done the cycle after the request, no writes
        s = done_cnt; w = wr_cnt;
        start_load(0);
        chk("t5_len0_done", 32'(bus.done_ld), 32'd1);
        #1;
        repeat (3) @(negedge CLK);
        chk("t5_len0_writes", 32'(wr_cnt - w), 32'd0);
        chk("t5_len0_dones", 32'(done_cnt - s), 32'd1);

        // Reset after two bytes: partial word dropped, no write, no done
        prog = '{8'h11, 8'h22, 8'h33, 8'h44};
        s = done_cnt; w = wr_cnt;
        start_load(1);
        feed(0, 2, 1'b0);
        do_reset(1);
        repeat (3) @(negedge CLK);
        chk("t6_rst_writes", 32'(wr_cnt - w), 32'd0);
        chk("t6_rst_dones", 32'(done_cnt - s), 32'd0);
        chk("t6_rst_busy", 32'(bus.busy), 32'd0);
        prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        s = done_cnt; w = wr_cnt;
        start_load(1);
        feed(0, 4, 1'b0);
        wait_done(s);
        chk("t6_writes", 32'(wr_cnt - w), 32'd1);
        chk("t6_addr", last_addr, 32'h0);
        chk("t6_data", last_data, 32'hDDCC_BBAA);

        repeat (2) @(negedge CLK);
        chk("end_pending", 32'(exp_addr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
